// File: rtl/fan_mode_ctrl.sv
// Fan mode and auto-off timer controller: turns button pulses into the fan on/off flag,
// the speed level for the PWM selector, and a seconds countdown that switches the fan off.
module fan_mode_ctrl #(
    parameter int unsigned TICK_DIV        = 100_000_000,
    parameter int unsigned TIMER_STEP      = 30,
    parameter int unsigned TIMER_MAX_STEPS = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_speed,
    input  logic       i_btn_timer,
    input  logic       i_btn_off,
    output logic       o_FANOnOff,
    output logic [3:0] o_1000_value,
    output logic       o_timer_on,
    output logic [7:0] o_remain_sec
);

    localparam int unsigned PRESC_W = $clog2(TICK_DIV);
    localparam int unsigned STEP_W  = $clog2(TIMER_MAX_STEPS + 1);

    typedef enum logic {
        S_OFF = 1'b0,
        S_ON  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [STEP_W-1:0]  step;
    logic [STEP_W-1:0]  step_n;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_n;
    logic [3:0]         level_n;
    logic [7:0]         remain_n;
    logic               timer_on_n;
    logic               fan_on_n;

    logic tick_c;
    logic expire_c;
    logic force_off_c;

    // Any path that lands in S_OFF: off button, countdown expiry, or speed wrap from level 3.
    always_comb begin
        tick_c      = (presc == PRESC_W'(TICK_DIV - 1));
        expire_c    = tick_c && o_timer_on && (o_remain_sec == 8'd1);
        force_off_c = i_btn_off || expire_c ||
                      ((state == S_ON) && i_btn_speed && (o_1000_value == 4'd3));
    end

    // State register together with the registered datapath and outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= S_OFF;
            step         <= '0;
            presc        <= '0;
            o_FANOnOff   <= 1'b0;
            o_1000_value <= 4'd0;
            o_timer_on   <= 1'b0;
            o_remain_sec <= 8'd0;
        end else begin
            state        <= state_n;
            step         <= step_n;
            presc        <= presc_n;
            o_FANOnOff   <= fan_on_n;
            o_1000_value <= level_n;
            o_timer_on   <= timer_on_n;
            o_remain_sec <= remain_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        if (force_off_c) begin
            state_n = S_OFF;
        end else if (i_btn_speed && (state == S_OFF)) begin
            state_n = S_ON;
        end
    end

    // Output and datapath next values; a timer reload preempts the decrement on the same tick.
    always_comb begin
        level_n    = o_1000_value;
        step_n     = step;
        remain_n   = o_remain_sec;
        timer_on_n = o_timer_on;
        presc_n    = tick_c ? '0 : presc + PRESC_W'(1);

        if (force_off_c) begin
            level_n    = 4'd0;
            step_n     = '0;
            remain_n   = 8'd0;
            timer_on_n = 1'b0;
            presc_n    = '0;
        end else begin
            if (i_btn_speed) begin
                level_n = (state == S_OFF) ? 4'd1 : o_1000_value + 4'd1;
            end
            if (i_btn_timer && (state == S_ON)) begin
                step_n     = (step == STEP_W'(TIMER_MAX_STEPS)) ? '0 : step + STEP_W'(1);
                remain_n   = 8'(32'(step_n) * TIMER_STEP);
                timer_on_n = (step_n != '0);
                presc_n    = '0;
            end else if (tick_c && o_timer_on) begin
                remain_n = o_remain_sec - 8'd1;
            end
        end

        fan_on_n = (state_n == S_ON);
    end

endmodule
